// File: rtl/truth_table_scanner_if.sv
// Bundle of signals between the truth-table scanner and whoever drives and
// observes it (the logic stage under test plus the controlling host).
//   start, abort  : host requests (sweep / cancel)
//   F             : result of the 3-input logic stage
//   A, B, C       : stage inputs, {A,B,C} is the current vector index
//   busy, done    : sweep status, done is a one-cycle completion pulse
//   table_out     : last completed truth table, bit i = F at index i
//   table_valid   : table_out holds a completed sweep
//   ones_count    : number of ones in table_out (0..8)
//   mismatch      : table_out differs from the golden pattern
interface truth_table_scanner_if;
  logic       start;
  logic       abort;
  logic       F;
  logic       A;
  logic       B;
  logic       C;
  logic       busy;
  logic       done;
  logic [7:0] table_out;
  logic       table_valid;
  logic [3:0] ones_count;
  logic       mismatch;

  // Scanner side
  modport slave (
    input  start, abort, F,
    output A, B, C, busy, done, table_out, table_valid, ones_count, mismatch
  );

  // Host / logic-stage side
  modport master (
    output start, abort, F,
    input  A, B, C, busy, done, table_out, table_valid, ones_count, mismatch
  );
endinterface

// File: rtl/truth_table_scanner.sv
// Self-test sequencer for a 3-input combinational logic stage.
// Steps {A,B,C} through indices 0..7, holds each for SETTLE_CYCLES cycles,
// samples F on one extra cycle, assembles the 8 samples into a truth table,
// then publishes the table with its popcount and a compare against EXPECTED.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous reset, active low
//   bus    : truth_table_scanner_if.slave (start/abort/F in, A/B/C and
//            status/result out); every output is registered.
module truth_table_scanner #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [7:0] EXPECTED      = 8'h30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  truth_table_scanner_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  // Last value of the settle counter before moving on to the sample cycle.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] index_q, index_d;
  logic [3:0] settle_q, settle_d;
  logic [2:0] abc_q, abc_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] table_q, table_d;
  logic       valid_q, valid_d;
  logic [3:0] count_q, count_d;
  logic       mismatch_q, mismatch_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Shadow table with the current F already merged in, so the final vector
  // lands in the published table on the very edge that completes the sweep.
  logic [7:0] captured;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  // Next-state and output logic. Everything holds by default; done is a
  // pulse so it defaults low.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    settle_d   = settle_q;
    abc_d      = abc_q;
    shadow_d   = shadow_q;
    table_d    = table_q;
    valid_d    = valid_q;
    count_d    = count_q;
    mismatch_d = mismatch_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    captured           = shadow_q;
    captured[index_q]  = bus.F;

    unique case (state_q)
      IDLE: begin
        // abort has priority over start so a simultaneous pair does nothing
        if (bus.start && !bus.abort) begin
          state_d  = DRIVE;
          index_d  = 3'd0;
          settle_d = 4'd0;
          abc_d    = 3'd0;
          shadow_d = 8'h00;
          busy_d   = 1'b1;
          valid_d  = 1'b0;
        end
      end

      DRIVE: begin
        if (bus.abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          abc_d   = 3'd0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      SAMPLE: begin
        if (bus.abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          abc_d   = 3'd0;
        end else if (index_q != 3'd7) begin
          shadow_d = captured;
          index_d  = index_q + 3'd1;
          abc_d    = index_q + 3'd1;
          settle_d = 4'd0;
          state_d  = DRIVE;
        end else begin
          // Last vector: publish everything together on this edge.
          shadow_d   = captured;
          table_d    = captured;
          count_d    = popcount8(captured);
          mismatch_d = (captured != EXPECTED);
          valid_d    = 1'b1;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          abc_d      = 3'd0;
          state_d    = DONE;
        end
      end

      DONE: begin
        // One-cycle completion state; start is deliberately not looked at.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      index_q    <= 3'd0;
      settle_q   <= 4'd0;
      abc_q      <= 3'd0;
      shadow_q   <= 8'h00;
      table_q    <= 8'h00;
      valid_q    <= 1'b0;
      count_q    <= 4'd0;
      mismatch_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      settle_q   <= settle_d;
      abc_q      <= abc_d;
      shadow_q   <= shadow_d;
      table_q    <= table_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      mismatch_q <= mismatch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.A           = abc_q[2];
  assign bus.B           = abc_q[1];
  assign bus.C           = abc_q[0];
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.table_out   = table_q;
  assign bus.table_valid = valid_q;
  assign bus.ones_count  = count_q;
  assign bus.mismatch    = mismatch_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Testbench for truth_table_scanner. Models the logic stage in several
// flavours (A&~B, stuck-at-1, stuck-at-0, and an A&~B that only shows the
// right value on the final cycle of each hold), pushes the expected result
// of each sweep into a scoreboard and lets a monitor compare on every done.
module tb_truth_table_scanner;

  localparam int SETTLE = 2;
  localparam int SWEEP  = 8 * (SETTLE + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   mode  = 0;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [7:0] tbl;
    logic [3:0] cnt;
    logic       mis;
    int         due;
  } exp_t;

  exp_t sb[$];

  truth_table_scanner_if bus();

  truth_table_scanner #(
    .SETTLE_CYCLES(SETTLE),
    .EXPECTED     (8'h30)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Age of the current {A,B,C} value in cycles, so mode 3 can show the
  // correct F only on the final cycle of each hold.
  int   age = 0;
  logic [2:0] last_abc = 3'd0;
  logic last_busy = 1'b0;

  always @(negedge clk) begin
    if (!bus.busy || !last_busy || ({bus.A, bus.B, bus.C} != last_abc)) age <= 0;
    else age <= age + 1;
    last_abc  <= {bus.A, bus.B, bus.C};
    last_busy <= bus.busy;
  end

  // Logic stage model.
  assign bus.F = (mode == 0) ? (bus.A & ~bus.B) :
                 (mode == 1) ? 1'b1 :
                 (mode == 2) ? 1'b0 :
                 ((age == SETTLE) ? (bus.A & ~bus.B) : ~(bus.A & ~bus.B));

  // Expected result of one sweep from the stage's truth function.
  function automatic exp_t model(input int m, input int due);
    exp_t e;
    int a, b, f, ones;
    e.tbl = 8'h00;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      a = (i / 4) % 2;
      b = (i / 2) % 2;
      if (m == 1) f = 1;
      else if (m == 2) f = 0;
      else f = (a == 1 && b == 0) ? 1 : 0;
      e.tbl[i] = f[0];
      ones += f;
    end
    e.cnt = 4'(ones);
    e.mis = (e.tbl != 8'h30);
    e.due = due;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Drive start/abort for one edge; optionally record the sweep it launches.
  task automatic applyStimulus(input int m, input bit st, input bit ab, input bit expect_sweep);
    mode = m;
    bus.start = st;
    bus.abort = ab;
    if (expect_sweep) sb.push_back(model(m, cycle + 1 + SWEEP));
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      tick();
      n++;
    end
    if (!bus.done) checkOutput("done_timeout", bus.done, 1);
  endtask

  task automatic waitIndex(input logic [2:0] idx, input int budget);
    int n = 0;
    while ({bus.A, bus.B, bus.C} != idx && n < budget) begin
      tick();
      n++;
    end
    checkOutput("reach_index", {bus.A, bus.B, bus.C}, idx);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_busy"},  bus.busy, 0);
    checkOutput({tag, "_done"},  bus.done, 0);
    checkOutput({tag, "_abc"},   {bus.A, bus.B, bus.C}, 0);
    checkOutput({tag, "_table"}, bus.table_out, 0);
    checkOutput({tag, "_valid"}, bus.table_valid, 0);
    checkOutput({tag, "_count"}, bus.ones_count, 0);
    checkOutput({tag, "_mis"},   bus.mismatch, 0);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      checkOutput("done_one_cycle", done_prev, 0);
      checkOutput("done_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("done_time",   cycle, e.due);
        checkOutput("table_out",   bus.table_out, e.tbl);
        checkOutput("ones_count",  bus.ones_count, e.cnt);
        checkOutput("mismatch",    bus.mismatch, e.mis);
        checkOutput("table_valid", bus.table_valid, 1);
        checkOutput("busy_at_done", bus.busy, 0);
        checkOutput("abc_at_done", {bus.A, bus.B, bus.C}, 0);
      end
    end
    done_prev <= bus.done;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst_n = 1'b0;
    #12;
    checkReset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Nominal sweep with the full drive sequence watched.
    applyStimulus(0, 1, 0, 1);
    for (int j = 0; j <= SWEEP; j++) begin
      checkOutput("abc_seq", {bus.A, bus.B, bus.C}, (j < SWEEP) ? (j / (SETTLE + 1)) : 0);
      checkOutput("busy_seq", bus.busy, (j < SWEEP) ? 1 : 0);
      checkOutput("done_seq", bus.done, (j == SWEEP) ? 1 : 0);
      if (j < SWEEP) tick();
    end
    tick();
    checkOutput("done_cleared", bus.done, 0);

    // Stuck-at faults.
    applyStimulus(1, 1, 0, 1);
    waitDone(SWEEP + 4);
    tick();
    applyStimulus(2, 1, 0, 1);
    waitDone(SWEEP + 4);
    tick();

    // Good sweep, then abort the next one at index 4.
    applyStimulus(0, 1, 0, 1);
    waitDone(SWEEP + 4);
    tick();
    applyStimulus(0, 1, 0, 0);
    waitIndex(3'd4, SWEEP);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checkOutput("abort_busy",  bus.busy, 0);
    checkOutput("abort_abc",   {bus.A, bus.B, bus.C}, 0);
    checkOutput("abort_table", bus.table_out, 8'h30);
    checkOutput("abort_valid", bus.table_valid, 0);
    checkOutput("abort_done",  bus.done, 0);
    repeat (SWEEP + 4) tick();
    checkOutput("abort_table_kept", bus.table_out, 8'h30);

    // start pulses while busy must not disturb timing.
    applyStimulus(0, 1, 0, 1);
    repeat (4) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    waitDone(SWEEP + 4);
    tick();

    // start and abort together in IDLE.
    applyStimulus(0, 1, 1, 0);
    checkOutput("start_abort_busy", bus.busy, 0);
    tick();
    checkOutput("start_abort_busy2", bus.busy, 0);

    // start held high: second sweep begins the cycle after DONE.
    mode = 3;
    bus.start = 1'b1;
    sb.push_back(model(3, cycle + 1 + SWEEP));
    sb.push_back(model(3, cycle + 1 + SWEEP + 2 + SWEEP));
    tick();
    waitDone(SWEEP + 4);
    tick();
    checkOutput("held_idle_busy", bus.busy, 0);
    tick();
    bus.start = 1'b0;
    checkOutput("held_restart_busy", bus.busy, 1);
    waitDone(SWEEP + 4);
    tick();

    // Asynchronous reset mid-sweep, then a fresh sweep.
    applyStimulus(0, 1, 0, 0);
    waitIndex(3'd5, SWEEP);
    #2 rst_n = 1'b0;
    #1 checkReset("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    applyStimulus(0, 1, 0, 1);
    waitDone(SWEEP + 4);
    tick();

    // Randomized sweeps over all stage models.
    for (int r = 0; r < 8; r++) begin
      int m;
      m = int'($urandom_range(0, 3));
      repeat ($urandom_range(0, 3)) tick();
      applyStimulus(m, 1, 0, 1);
      repeat ($urandom_range(1, 10)) tick();
      bus.start = ($urandom_range(0, 1) == 1);
      tick();
      bus.start = 1'b0;
      waitDone(SWEEP + 4);
      tick();
    end

    repeat (3) tick();
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequencer that drives the 3-input combinational logic stage: outputs A, B, C step through all 8 input combinations, and the stage's result F is sampled for each one.
- Assembles the 8 samples into a truth-table word, counts the ones, and compares the word against an expected pattern.
- Sits directly upstream of the logic stage (feeds A/B/C) and closes the loop on its F output. Used for board-level self-test of that stage.

Parameters:
- SETTLE_CYCLES, 2, number of cycles A/B/C are held stable before F is sampled; legal range 1..15.
- EXPECTED, 8'h30, golden truth table; bit i is the F value for index i = {A,B,C}.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- start  input  1  sweep request; sampled only in IDLE.
- abort  input  1  cancels a sweep in progress.
- F  input  1  result of the logic stage (combinational function of A/B/C).
- A  output  1  stage input, MSB of the index.
- B  output  1  stage input, middle bit of the index.
- C  output  1  stage input, LSB of the index.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- table_out  output  8  last completed truth table; bit i = F at index i.
- table_valid  output  1  table_out holds a completed sweep.
- ones_count  output  4  popcount of table_out, 0..8.
- mismatch  output  1  table_out != EXPECTED.

Behaviour:
- Reset (async, rst_n=0) forces the following values immediately:
  - state = IDLE; A/B/C = 0.
  - busy = 0; done = 0.
  - table_out = 8'h00; table_valid = 0.
  - ones_count = 0; mismatch = 0.
  - Internal index and settle counter = 0.
- All outputs are registered; F is the only input used combinationally (captured by a flop).
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 and abort=0 at edge E0 → DRIVE.
  - At the same edge: {A,B,C} = 3'b000, index = 0, busy = 1, table_valid = 0, settle counter cleared.
- DRIVE:
  - Holds {A,B,C} = index for exactly SETTLE_CYCLES cycles (counter 0..SETTLE_CYCLES-1), then → SAMPLE.
- SAMPLE (one cycle):
  - At its closing edge, F is written into shadow bit [index].
  - If index < 7: index increments, {A,B,C} takes the new index, → DRIVE with the counter cleared.
  - If index == 7: → DONE.
- Per-vector cost: SETTLE_CYCLES+1 cycles. Vector k is captured at edge E0 + (k+1)(SETTLE_CYCLES+1).
- Completion, at the SAMPLE→DONE edge (E0 + 8(SETTLE_CYCLES+1)), all of these update together:
  - table_out = shadow, including bit 7 captured at that same edge.
  - ones_count = popcount(table_out); mismatch = (table_out != EXPECTED).
  - table_valid = 1; done = 1; busy = 0.
  - {A,B,C} returns to 000.
- DONE: lasts one cycle, then → IDLE with done = 0. start is ignored during DONE.
- The index stops at 7; there is no wrap-around. Exactly one pass per start.
- start while busy: ignored, with no effect on timing.
- Back-to-back sweeps: start held high makes the next sweep begin on the first IDLE cycle.
- abort=1 in DRIVE or SAMPLE at the next edge:
  - → IDLE; busy = 0; {A,B,C} = 000; no done pulse.
  - table_out, ones_count and mismatch keep their previous values.
  - table_valid stays 0, because it was cleared at start.
- abort and start together in IDLE: abort wins, no sweep. abort in IDLE/DONE: no effect.
- Reset mid-sweep: immediate return to reset values; no partial table is ever published.
- Width rules:
  - index is 3 bits; settle counter is 4 bits.
  - ones_count is 4 bits so that 8 is representable.

Test Plan:
- Nominal: reset, then start pulse with F = A&~B and SETTLE_CYCLES=2.
  - done high for exactly 1 cycle, 24 edges after the start edge.
  - table_out = 8'h30, ones_count = 2, mismatch = 0, table_valid = 1, busy low at done.
- Drive sequence: monitor {A,B,C} during a sweep.
  - Values are 000,001,…,111, each held 3 cycles, then return to 000.
  - F is sampled exactly on the last cycle of each hold.
- Fault injection: model F stuck at 1 → table_out = 8'hFF, ones_count = 8, mismatch = 1. Model F stuck at 0 → table_out = 8'h00, ones_count = 0, mismatch = 1.
- Abort: complete one good sweep (8'h30), start a second, assert abort at index 4.
  - busy = 0 next cycle, no done pulse, A/B/C = 000.
  - table_out stays 8'h30; table_valid = 0.
- Protocol edges:
  - start pulses while busy → single done, at the original time.
  - start+abort together in IDLE → busy stays 0.
  - start held high → second sweep begins the cycle after DONE.
- Reset mid-sweep: rst_n low asynchronously at index 5 → all outputs at reset values immediately. A fresh start after release → table_out = 8'h30.
